// File: rtl/lut_dump_capture.sv
// LUT dump capture engine.
// A rising edge on dump_trig latches the requested sample count (clamped to the
// buffer depth) and writes that many valid samples to BRAM addresses 0..N-1,
// then raises a sticky done flag that software polls before reading the buffer.
//
// Sample stream handshake: sample_valid qualifies sample_in in the cycle it is
// high; there is no ready/backpressure, so every valid sample seen while
// capturing is accepted and written one cycle later. Samples outside a
// capture are dropped.
module lut_dump_capture #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  user_clk,
    input  logic                  user_rst,
    input  logic [31:0]           buffer_size,
    input  logic                  dump_trig,
    input  logic                  dump_clr,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    output logic                  bram_we,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   words_written,
    output logic [1:0]            fsm_state
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    // Buffer depth in words; requests larger than this are clamped.
    localparam logic [31:0] DEPTH = 32'(1) << ADDR_WIDTH;

    logic [1:0]            state;
    logic                  trig_d;
    logic                  start;
    logic [ADDR_WIDTH:0]   n_lat;
    logic [ADDR_WIDTH:0]   size_clamped;
    logic [ADDR_WIDTH:0]   ww_inc;

    // Edge detect, size clamp and next write count.
    always_comb begin
        start        = dump_trig & ~trig_d;
        size_clamped = (buffer_size > DEPTH) ? DEPTH[ADDR_WIDTH:0] : buffer_size[ADDR_WIDTH:0];
        ww_inc       = words_written + {{ADDR_WIDTH{1'b0}}, 1'b1};
    end

    // Capture FSM with registered BRAM write port; clear beats a same-cycle start.
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            state         <= ST_IDLE;
            trig_d        <= 1'b0;
            n_lat         <= '0;
            words_written <= '0;
            bram_we       <= 1'b0;
            bram_addr     <= '0;
            bram_din      <= '0;
        end else begin
            trig_d  <= dump_trig;
            bram_we <= 1'b0;
            if (dump_clr) begin
                state         <= ST_IDLE;
                words_written <= '0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            n_lat         <= size_clamped;
                            words_written <= '0;
                            state         <= (size_clamped == '0) ? ST_DONE : ST_CAPTURE;
                        end
                    end
                    ST_CAPTURE: begin
                        // A new trigger edge here is ignored; software clears first.
                        if (sample_valid) begin
                            bram_we       <= 1'b1;
                            bram_addr     <= words_written[ADDR_WIDTH-1:0];
                            bram_din      <= sample_in;
                            words_written <= ww_inc;
                            if (ww_inc == n_lat) begin
                                state <= ST_DONE;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Status flags decode straight from the state so reset clears them at once.
    always_comb begin
        busy      = (state == ST_CAPTURE);
        done      = (state == ST_DONE);
        fsm_state = state;
    end

endmodule

// File: tb/tb_lut_dump_capture.sv
// Bench for lut_dump_capture: vector table, directed multi-cycle sequences and
// randomized traffic, all checked against a transaction-level reference model.
module tb_lut_dump_capture;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int unsigned DEPTH = 1 << AW;

    logic          user_clk = 1'b0;
    logic          user_rst;
    logic [31:0]   buffer_size;
    logic          dump_trig;
    logic          dump_clr;
    logic [DW-1:0] sample_in;
    logic          sample_valid;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic          bram_we;
    logic          busy;
    logic          done;
    logic [AW:0]   words_written;
    logic [1:0]    fsm_state;

    lut_dump_capture #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .user_clk      (user_clk),
        .user_rst      (user_rst),
        .buffer_size   (buffer_size),
        .dump_trig     (dump_trig),
        .dump_clr      (dump_clr),
        .sample_in     (sample_in),
        .sample_valid  (sample_valid),
        .bram_addr     (bram_addr),
        .bram_din      (bram_din),
        .bram_we       (bram_we),
        .busy          (busy),
        .done          (done),
        .words_written (words_written),
        .fsm_state     (fsm_state)
    );

    // Clock
    always #5 user_clk = ~user_clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard: expected {addr, data} writes
    logic [AW+DW-1:0] exp_q[$];

    // Reference model: a capture is "a job of m_n words, m_count done so far"
    bit          m_active;
    bit          m_done;
    bit          m_trig_prev;
    int unsigned m_n;
    int unsigned m_count;
    bit          m_we;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active    = 1'b0;
        m_done      = 1'b0;
        m_trig_prev = 1'b0;
        m_n         = 0;
        m_count     = 0;
        m_we        = 1'b0;
    endtask

    // Driver: apply one cycle of inputs, advance the model, clock, then check.
    task automatic drive_cycle(input logic clr, input logic trig, input logic [31:0] size,
                               input logic valid, input logic [DW-1:0] data);
        logic [AW+DW-1:0] item;
        logic [AW-1:0]    a;
        dump_clr     = clr;
        dump_trig    = trig;
        buffer_size  = size;
        sample_valid = valid;
        sample_in    = data;
        m_we = 1'b0;
        if (clr) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_count  = 0;
        end else if (trig && !m_trig_prev && !m_active) begin
            m_n     = (size > DEPTH) ? DEPTH : size;
            m_count = 0;
            m_active = (m_n != 0);
            m_done   = (m_n == 0);
        end else if (m_active && valid) begin
            a = m_count[AW-1:0];
            exp_q.push_back({a, data});
            m_we = 1'b1;
            m_count++;
            if (m_count == m_n) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
        end
        m_trig_prev = trig;
        @(posedge user_clk);
        #1;
        check("model_busy", busy, m_active);
        check("model_done", done, m_done);
        check("model_words_written", words_written, m_count);
        check("model_bram_we", bram_we, m_we);
        if (m_we || bram_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                item = exp_q.pop_front();
                check("write_addr", bram_addr, item[AW+DW-1:DW]);
                check("write_data", bram_din, item[DW-1:0]);
            end
        end
    endtask

    typedef struct {
        logic        clr;
        logic        trig;
        logic [31:0] size;
        logic        valid;
        logic [31:0] data;
        logic        e_busy;
        logic        e_done;
        logic        e_we;
        logic [9:0]  e_addr;
        logic [31:0] e_din;
        logic [10:0] e_ww;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(logic clr, logic trig, logic [31:0] size, logic valid,
                                logic [31:0] data, logic e_busy, logic e_done, logic e_we,
                                logic [9:0] e_addr, logic [31:0] e_din, logic [10:0] e_ww);
        vec_t v;
        v.clr = clr; v.trig = trig; v.size = size; v.valid = valid; v.data = data;
        v.e_busy = e_busy; v.e_done = e_done; v.e_we = e_we;
        v.e_addr = e_addr; v.e_din = e_din; v.e_ww = e_ww;
        return v;
    endfunction

    int          writes;
    logic [AW-1:0] last_addr;
    logic        rtrig, rclr, rvalid;
    int unsigned sel, sz, cyc, eff;
    logic [31:0] rsize;

    initial begin
        // Reset block
        user_rst     = 1'b1;
        dump_trig    = 1'b0;
        dump_clr     = 1'b0;
        buffer_size  = '0;
        sample_in    = '0;
        sample_valid = 1'b0;
        model_reset();
        repeat (3) @(posedge user_clk);
        #1;
        check("rst_bram_we", bram_we, 0);
        check("rst_bram_addr", bram_addr, 0);
        check("rst_bram_din", bram_din, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_words_written", words_written, 0);
        user_rst = 1'b0;

        // Vector table: size-4 capture with a gap, zero-size trigger, clear rules
        tbl[0]  = mk(0, 0, 4, 0, 32'h00, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 4, 1, 32'hAA, 1, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 4, 1, 32'h10, 1, 0, 1, 0, 32'h10, 1);
        tbl[3]  = mk(0, 1, 4, 1, 32'h11, 1, 0, 1, 1, 32'h11, 2);
        tbl[4]  = mk(0, 1, 4, 0, 32'hBB, 1, 0, 0, 0, 0, 2);
        tbl[5]  = mk(0, 1, 4, 1, 32'h12, 1, 0, 1, 2, 32'h12, 3);
        tbl[6]  = mk(0, 1, 4, 1, 32'h13, 0, 1, 1, 3, 32'h13, 4);
        tbl[7]  = mk(0, 1, 4, 1, 32'h14, 0, 1, 0, 0, 0, 4);
        tbl[8]  = mk(0, 0, 0, 0, 32'h00, 0, 1, 0, 0, 0, 4);
        tbl[9]  = mk(0, 1, 0, 1, 32'h55, 0, 1, 0, 0, 0, 0);
        tbl[10] = mk(1, 1, 0, 0, 32'h00, 0, 0, 0, 0, 0, 0);
        tbl[11] = mk(0, 0, 2, 0, 32'h00, 0, 0, 0, 0, 0, 0);
        tbl[12] = mk(1, 1, 2, 0, 32'h00, 0, 0, 0, 0, 0, 0);
        tbl[13] = mk(0, 1, 2, 1, 32'h66, 0, 0, 0, 0, 0, 0);
        tbl[14] = mk(0, 0, 2, 0, 32'h00, 0, 0, 0, 0, 0, 0);
        tbl[15] = mk(0, 1, 2, 0, 32'h00, 1, 0, 0, 0, 0, 0);
        tbl[16] = mk(0, 1, 2, 1, 32'h20, 1, 0, 1, 0, 32'h20, 1);
        tbl[17] = mk(0, 1, 2, 1, 32'h21, 0, 1, 1, 1, 32'h21, 2);
        for (int i = 0; i < 18; i++) begin
            drive_cycle(tbl[i].clr, tbl[i].trig, tbl[i].size, tbl[i].valid, tbl[i].data);
            check($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            check($sformatf("tbl%0d_done", i), done, tbl[i].e_done);
            check($sformatf("tbl%0d_we", i), bram_we, tbl[i].e_we);
            check($sformatf("tbl%0d_ww", i), words_written, tbl[i].e_ww);
            if (tbl[i].e_we) begin
                check($sformatf("tbl%0d_addr", i), bram_addr, tbl[i].e_addr);
                check($sformatf("tbl%0d_din", i), bram_din, tbl[i].e_din);
            end
        end

        // Size 3 with valid toggling 1,0,1,0,1: write gaps follow input gaps
        drive_cycle(0, 0, 3, 0, 0);
        drive_cycle(0, 1, 3, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive_cycle(0, 1, 3, (i % 2) == 0, 32'h30 + i);
            check($sformatf("toggle_we%0d", i), bram_we, (i % 2) == 0);
        end
        check("toggle_done", done, 1);
        check("toggle_ww", words_written, 3);
        check("toggle_last_addr", bram_addr, 2);
        drive_cycle(0, 1, 3, 1, 32'h99);
        check("toggle_no_extra", bram_we, 0);

        // Oversize request clamps to the full buffer with no wrap
        drive_cycle(0, 0, 5000, 0, 0);
        drive_cycle(0, 1, 5000, 0, 0);
        writes = 0;
        last_addr = '0;
        for (int i = 0; i < 1030; i++) begin
            drive_cycle(0, 1, 5000, 1, i);
            if (bram_we) begin
                writes++;
                last_addr = bram_addr;
            end
        end
        check("clamp_writes", writes, 1024);
        check("clamp_last_addr", last_addr, 10'h3FF);
        check("clamp_ww", words_written, 1024);
        check("clamp_done", done, 1);

        // Mid-capture: size change and second trigger edge are ignored
        drive_cycle(0, 0, 8, 0, 0);
        drive_cycle(0, 1, 8, 0, 0);
        writes = 0;
        drive_cycle(0, 1, 8, 1, 32'h40); writes += bram_we;
        drive_cycle(0, 1, 8, 1, 32'h41); writes += bram_we;
        drive_cycle(0, 1, 2, 1, 32'h42); writes += bram_we;
        drive_cycle(0, 0, 2, 1, 32'h43); writes += bram_we;
        drive_cycle(0, 1, 2, 1, 32'h44); writes += bram_we;
        check("mid_retrig_busy", busy, 1);
        check("mid_retrig_ww", words_written, 5);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(0, 1, 2, 1, 32'h45 + i);
            writes += bram_we;
        end
        check("mid_writes", writes, 8);
        check("mid_ww", words_written, 8);
        check("mid_done", done, 1);

        // Mid-capture clear returns to idle
        drive_cycle(0, 0, 8, 0, 0);
        drive_cycle(0, 1, 8, 0, 0);
        drive_cycle(0, 1, 8, 1, 32'h50);
        drive_cycle(0, 1, 8, 1, 32'h51);
        drive_cycle(1, 1, 8, 1, 32'h52);
        check("clr_busy", busy, 0);
        check("clr_done", done, 0);
        check("clr_ww", words_written, 0);
        check("clr_we", bram_we, 0);
        drive_cycle(0, 1, 8, 1, 32'h53);
        check("clr_stays_idle", busy, 0);

        // Asynchronous reset during capture, trigger held through release
        drive_cycle(0, 0, 8, 0, 0);
        drive_cycle(0, 1, 8, 0, 0);
        drive_cycle(0, 1, 8, 1, 32'h60);
        drive_cycle(0, 1, 8, 1, 32'h61);
        #2;
        user_rst = 1'b1;
        #1;
        check("arst_bram_we", bram_we, 0);
        check("arst_bram_addr", bram_addr, 0);
        check("arst_bram_din", bram_din, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_ww", words_written, 0);
        model_reset();
        repeat (2) @(posedge user_clk);
        #1;
        user_rst = 1'b0;
        drive_cycle(0, 1, 8, 0, 0);
        check("arst_restart_busy", busy, 1);
        drive_cycle(0, 1, 8, 1, 32'h70);
        check("arst_restart_addr", bram_addr, 0);
        drive_cycle(1, 0, 8, 0, 0);

        // Randomized traffic against the model
        for (int r = 0; r < 30; r++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      sz = 0;
            else if (sel == 1) sz = $urandom_range(1020, 1030);
            else if (sel == 2) sz = $urandom();
            else               sz = $urandom_range(1, 24);
            eff = (sz > DEPTH) ? DEPTH : sz;
            cyc = eff * 2 + 12;
            drive_cycle(0, 0, sz, 0, 0);
            drive_cycle(0, 1, sz, $urandom_range(0, 1) == 1, $urandom());
            for (int c = 0; c < int'(cyc); c++) begin
                rtrig  = ($urandom_range(0, 5) == 0);
                rclr   = ($urandom_range(0, 199) == 0);
                rvalid = ($urandom_range(0, 3) != 0);
                rsize  = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 30)) : sz;
                drive_cycle(rclr, rtrig, rsize, rvalid, $urandom());
            end
        end

        check("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
